// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types for the UART transmit controller: line configuration,
// controller FSM states and the configuration applied out of reset.
package data_types_pkg;

    typedef struct packed {
        logic [15:0] br_div;
        logic        word;
        logic        stop;
        logic        en;
    } config_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT
    } tx_ctrl_state_e;

    localparam config_t CFG_RESET = '{br_div: 16'd8, word: 1'b0, stop: 1'b0, en: 1'b0};

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Bundle of host-side and uart_tx-side signals around the transmit controller.
// The master view belongs to whoever feeds words/config and models uart_tx;
// the slave view belongs to the controller itself.
import data_types_pkg::*;

interface uart_tx_ctrl_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 9
);
    logic                         wr_valid;
    logic [DATA_W-1:0]            wr_data;
    logic                         wr_ready;
    logic                         cfg_wr;
    config_t                      cfg_in;
    config_t                      tx_cfg;
    logic [DATA_W-1:0]            tx_data;
    logic                         tx_enable;
    logic                         tx_idle;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         busy;

    modport master (
        output wr_valid, wr_data, cfg_wr, cfg_in, tx_idle,
        input  wr_ready, tx_cfg, tx_data, tx_enable, count, busy
    );

    modport slave (
        input  wr_valid, wr_data, cfg_wr, cfg_in, tx_idle,
        output wr_ready, tx_cfg, tx_data, tx_enable, count, busy
    );

endinterface

// File: rtl/uart_tx_ctrl_fifo.sv
// Small synchronous FIFO with occupancy count. A push while full is refused
// even if a pop happens in the same cycle; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Transmit controller: buffers host words, hands them to uart_tx one frame at
// a time and only swaps the line configuration between frames.
import data_types_pkg::*;

module uart_tx_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 9
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_ctrl_if.slave bus
);
    localparam logic [DATA_W-1:0] BIT8_MASK = {{(DATA_W-1){1'b0}}, 1'b1} << 8;

    tx_ctrl_state_e    state;
    tx_ctrl_state_e    state_next;
    config_t           pend_cfg;
    logic              pend_v;
    config_t           tx_cfg_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_enable_q;
    logic              apply_cfg;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.wr_valid),
        .pop     (fifo_pop),
        .wr_data (bus.wr_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (bus.count)
    );

    assign bus.wr_ready  = !fifo_full;
    assign bus.busy      = (state != IDLE) || !fifo_empty;
    assign bus.tx_cfg    = tx_cfg_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_enable = tx_enable_q;

    // Next-state decode; a pending config wins over starting a new frame.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        apply_cfg  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_v && bus.tx_idle) begin
                    apply_cfg = 1'b1;
                end else if (!fifo_empty && tx_cfg_q.en && bus.tx_idle) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                fifo_pop   = 1'b1;
                state_next = START;
            end
            START: begin
                if (!bus.tx_idle) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.tx_idle) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered frame request and data; bit 8 is dropped in 8-bit mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_enable_q <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            tx_enable_q <= (state_next == START);
            if (state == LOAD) begin
                tx_data_q <= tx_cfg_q.word ? fifo_head : (fifo_head & ~BIT8_MASK);
            end
        end
    end

    // Pending/active config; a strobe in the apply cycle stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cfg_q <= CFG_RESET;
            pend_cfg <= CFG_RESET;
            pend_v   <= 1'b0;
        end else begin
            if (apply_cfg) begin
                tx_cfg_q <= pend_cfg;
                pend_v   <= 1'b0;
            end
            if (bus.cfg_wr) begin
                pend_cfg <= bus.cfg_in;
                pend_v   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a simple uart_tx frame model.
import data_types_pkg::*;

module tb_uart_tx_ctrl;
    localparam int DEPTH     = 8;
    localparam int DATA_W    = 9;
    localparam int FRAME_LEN = 10;
    localparam int BUDGET    = 2000;

    typedef struct {
        logic       word;
        logic [8:0] din;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_q;

    int total = 0;
    int bad   = 0;

    logic [8:0] sent_q [$];
    bit         sent_w [$];
    int         remaining;
    int         stab_err  = 0;
    int         cfg_err   = 0;
    int         en_rises  = 0;
    int         since_idle = 1000;
    int         min_gap   = 1000;
    int         rises0;
    logic       prev_en   = 1'b0;
    logic [DATA_W-1:0] prev_data;
    config_t    prev_cfg;
    vec_t       vecs [6];

    uart_tx_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    uart_tx_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    function automatic config_t mk_cfg(logic word, logic en);
        config_t c;
        c = '{br_div: 16'd8, word: word, stop: 1'b0, en: en};
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(config_t c);
        bus.cfg_in = c;
        bus.cfg_wr = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
    endtask

    task automatic apply_stimulus(logic [8:0] w);
        bus.wr_data  = w;
        bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_done(int n, string name);
        int cyc = 0;
        while ((sent_q.size() < n || bus.busy || !bus.tx_idle) && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        if (cyc >= BUDGET) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: timeout, frames seen %0d required %0d", name, sent_q.size(), n);
        end
    endtask

    // uart_tx model plus line monitors for data stability, config timing and gaps.
    initial begin
        bus.tx_idle = 1'b1;
        remaining   = 0;
        prev_data   = '0;
        prev_cfg    = CFG_RESET;
        forever begin
            @(negedge clk);
            if (rst_q === 1'b0) begin
                if ((prev_en || !bus.tx_idle) && bus.tx_data != prev_data) stab_err++;
                if (bus.tx_cfg != prev_cfg && !bus.tx_idle) cfg_err++;
            end
            since_idle++;
            if (bus.tx_enable && !prev_en) begin
                en_rises++;
                if (since_idle < min_gap) min_gap = since_idle;
            end
            prev_en   = bus.tx_enable;
            prev_data = bus.tx_data;
            prev_cfg  = bus.tx_cfg;
            if (rst) begin
                bus.tx_idle = 1'b1;
                remaining   = 0;
            end else if (bus.tx_idle && bus.tx_enable) begin
                bus.tx_idle = 1'b0;
                remaining   = FRAME_LEN;
                sent_q.push_back(bus.tx_data[8:0]);
                sent_w.push_back(bus.tx_cfg.word);
            end else if (!bus.tx_idle) begin
                remaining--;
                if (remaining == 0) begin
                    bus.tx_idle = 1'b1;
                    since_idle  = 0;
                end
            end
        end
    end

    // Main directed sequence.
    initial begin
        rst          = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_in   = CFG_RESET;

        vecs[0] = '{word: 1'b1, din: 9'h1FE, exp: 9'h1FE};
        vecs[1] = '{word: 1'b1, din: 9'h101, exp: 9'h101};
        vecs[2] = '{word: 1'b0, din: 9'h1FE, exp: 9'h0FE};
        vecs[3] = '{word: 1'b0, din: 9'h155, exp: 9'h055};
        vecs[4] = '{word: 1'b0, din: 9'h08E, exp: 9'h08E};
        vecs[5] = '{word: 1'b0, din: 9'h100, exp: 9'h000};

        repeat (3) tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset values");
        check_output("rst_tx_enable", 32'(bus.tx_enable), 32'd0);
        check_output("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check_output("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        check_output("rst_count", 32'(bus.count), 32'd0);
        check_output("rst_busy", 32'(bus.busy), 32'd0);
        check_output("rst_tx_cfg", 32'(bus.tx_cfg), 32'(CFG_RESET));

        $display("[TB] first frame latency");
        cfg_write(mk_cfg(1'b0, 1'b1));
        tick();
        tick();
        check_output("cfg_en_applied", 32'(bus.tx_cfg.en), 32'd1);
        check_output("no_enable_before_push", 32'(en_rises), 32'd0);
        apply_stimulus(9'h08E);
        check_output("count_after_push", 32'(bus.count), 32'd1);
        check_output("enable_n1", 32'(bus.tx_enable), 32'd0);
        tick();
        check_output("enable_n2", 32'(bus.tx_enable), 32'd0);
        tick();
        check_output("enable_n3", 32'(bus.tx_enable), 32'd1);
        check_output("data_n3", 32'(bus.tx_data), 32'h08E);
        tick();
        check_output("enable_fall", 32'(bus.tx_enable), 32'd0);
        wait_done(1, "frame1");
        check_output("sent_8e", 32'(sent_q[0]), 32'h08E);

        $display("[TB] back-to-back frames");
        sent_q.delete();
        sent_w.delete();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 9'h08E;
        tick();
        bus.wr_data  = 9'h081;
        tick();
        bus.wr_data  = 9'h0FF;
        tick();
        bus.wr_valid = 1'b0;
        wait_done(3, "b2b");
        check_output("b2b_0", 32'(sent_q[0]), 32'h08E);
        check_output("b2b_1", 32'(sent_q[1]), 32'h081);
        check_output("b2b_2", 32'(sent_q[2]), 32'h0FF);
        check_output("b2b_count", 32'(bus.count), 32'd0);
        check_output("b2b_gap_ok", 32'(min_gap >= 3), 32'd1);

        $display("[TB] config change mid-frame");
        sent_q.delete();
        sent_w.delete();
        apply_stimulus(9'h0AA);
        for (int i = 0; i < 20 && bus.tx_idle; i++) tick();
        check_output("frame_on_line", 32'(bus.tx_idle), 32'd0);
        cfg_write(mk_cfg(1'b1, 1'b1));
        apply_stimulus(9'h1FE);
        check_output("word_held", 32'(bus.tx_cfg.word), 32'd0);
        wait_done(2, "midcfg");
        check_output("midcfg_d0", 32'(sent_q[0]), 32'h0AA);
        check_output("midcfg_w0", 32'(sent_w[0]), 32'd0);
        check_output("midcfg_d1", 32'(sent_q[1]), 32'h1FE);
        check_output("midcfg_w1", 32'(sent_w[1]), 32'd1);
        check_output("midcfg_word", 32'(bus.tx_cfg.word), 32'd1);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].word != bus.tx_cfg.word) begin
                cfg_write(mk_cfg(vecs[i].word, 1'b1));
                tick();
                tick();
            end
            sent_q.delete();
            sent_w.delete();
            apply_stimulus(vecs[i].din);
            wait_done(1, $sformatf("vec%0d", i));
            check_output($sformatf("vec%0d_sent", i), 32'(sent_q[0]), 32'(vecs[i].exp));
            check_output($sformatf("vec%0d_word", i), 32'(sent_w[0]), 32'(vecs[i].word));
            check_output($sformatf("vec%0d_count", i), 32'(bus.count), 32'd0);
        end

        $display("[TB] fill with transmit disabled");
        cfg_write(mk_cfg(1'b0, 1'b0));
        repeat (3) tick();
        sent_q.delete();
        sent_w.delete();
        rises0 = en_rises;
        for (int i = 0; i < 9; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 9'(9'h010 + 9'(i));
            tick();
            if (i == 6) check_output("ready_after_7", 32'(bus.wr_ready), 32'd1);
            if (i == 7) check_output("ready_after_8", 32'(bus.wr_ready), 32'd0);
        end
        bus.wr_valid = 1'b0;
        check_output("full_count", 32'(bus.count), 32'd8);
        check_output("full_busy", 32'(bus.busy), 32'd1);
        check_output("no_enable_disabled", 32'(en_rises), 32'(rises0));
        cfg_write(mk_cfg(1'b0, 1'b1));
        wait_done(8, "drain");
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("drain_%0d", i), 32'(sent_q[i]), 32'(9'h010 + 9'(i)));
        end
        repeat (40) tick();
        check_output("drain_frames", 32'(sent_q.size()), 32'd8);

        $display("[TB] reset mid-frame");
        sent_q.delete();
        sent_w.delete();
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = 9'(9'h031 + 9'(i));
            tick();
        end
        bus.wr_valid = 1'b0;
        for (int i = 0; i < BUDGET && sent_q.size() < 2; i++) tick();
        check_output("reached_frame2", 32'(sent_q.size()), 32'd2);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_output("rr_count", 32'(bus.count), 32'd0);
        check_output("rr_enable", 32'(bus.tx_enable), 32'd0);
        check_output("rr_cfg", 32'(bus.tx_cfg), 32'(CFG_RESET));
        check_output("rr_busy", 32'(bus.busy), 32'd0);
        rst    = 1'b0;
        rises0 = en_rises;
        repeat (60) tick();
        check_output("rr_no_enable", 32'(en_rises), 32'(rises0));
        check_output("rr_frames", 32'(sent_q.size()), 32'd2);

        check_output("data_stable", 32'(stab_err), 32'd0);
        check_output("cfg_only_between", 32'(cfg_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
